// File: rtl/hs_arith_gray_cvt_sched.sv
// Round-robin scheduler sharing one bin->Gray / Gray->bin converter pair among NUM_REQ requesters.
// Optional grant statistics counter enabled by defining HS_ARITH_GCS_STAT_EN.
module hs_arith_gray_cvt_sched #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned TAG_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_rev,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_rev
`ifdef HS_ARITH_GCS_STAT_EN
  ,
  input  logic                     stat_clr,
  output logic [31:0]              stat_grants
`endif
);

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StFull  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [TAG_W-1:0] tag_q;
  logic             rev_q;
  logic [TAG_W-1:0] ptr_q, ptr_d;

  logic             can_accept;
  logic             grant_found;
  logic             grant_fire;
  logic [TAG_W-1:0] grant_idx;
  logic [TAG_W:0]   scan_idx;
  logic [WIDTH-1:0] sel_data;
  logic             sel_rev;
  logic [WIDTH-1:0] gray_res;
  logic [WIDTH-1:0] bin_res;
  logic [WIDTH-1:0] conv_res;

  logic [WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = int'(WIDTH) - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  assign can_accept = (state_q == StEmpty) || out_ready;

  // Scan from the RR pointer, wrapping at NUM_REQ; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (TAG_W+1)'(k);
      if (scan_idx >= (TAG_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (TAG_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[scan_idx[TAG_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[TAG_W-1:0];
      end
    end
  end

  // Gating with rst_n keeps req_ready low for the whole reset assertion.
  assign grant_fire = rst_n && can_accept && grant_found;
  assign req_ready  = grant_fire ? (NUM_REQ'(1) << grant_idx) : '0;

  assign sel_data = data_arr[grant_idx];
  assign sel_rev  = req_rev[grant_idx];
  assign gray_res = bin2gray(sel_data);
  assign bin_res  = gray2bin(sel_data);
  assign conv_res = sel_rev ? bin_res : gray_res;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_fire) begin
      ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (grant_fire) state_d = StFull;
      StFull:  if (out_ready && !grant_fire) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      tag_q   <= '0;
      rev_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (grant_fire) begin
        data_q <= conv_res;
        tag_q  <= grant_idx;
        rev_q  <= sel_rev;
      end
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_tag   = tag_q;
  assign out_rev   = rev_q;

`ifdef HS_ARITH_GCS_STAT_EN
  logic [31:0] stat_q;

  // Clear has priority over a coincident grant; count saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (stat_clr) begin
      stat_q <= '0;
    end else if (grant_fire && (stat_q != 32'hFFFF_FFFF)) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stat_grants = stat_q;
`endif

endmodule

// File: tb/tb_hs_arith_gray_cvt_sched.sv
// Randomized self-checking bench for hs_arith_gray_cvt_sched against a behavioural model.
module tb_hs_arith_gray_cvt_sched;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_rev;
  logic [N*W-1:0] req_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_tag;
  logic           out_rev;
`ifdef HS_ARITH_GCS_STAT_EN
  logic           stat_clr;
  logic [31:0]    stat_grants;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  bit          m_full;
  logic [W-1:0] m_data;
  int          m_tag;
  bit          m_rev;
  int          m_ptr;
  int unsigned m_stat;

  always #5 clk = ~clk;

  hs_arith_gray_cvt_sched #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rev    (req_rev),
    .req_data   (req_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
`ifdef HS_ARITH_GCS_STAT_EN
    .stat_clr   (stat_clr),
    .stat_grants(stat_grants),
`endif
    .out_rev    (out_rev)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_b2g(input logic [W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Binary bit k is the parity of all Gray bits at or above k.
  function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int k = 0; k < W; k++) b[k] = ^(g >> k);
    return b;
  endfunction

  // Called just after a falling edge with inputs already driven; ends on the next falling edge.
  task automatic step();
    int g;
    bit found;
    bit can;
    logic [N-1:0] exp_ready;
    logic [W-1:0] d;
    #1;
    found = 0;
    g = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_valid[(m_ptr + k) % N]) begin
        found = 1;
        g = (m_ptr + k) % N;
      end
    end
    can = !m_full || out_ready;
    exp_ready = (can && found) ? N'(1 << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
`ifdef HS_ARITH_GCS_STAT_EN
    if (stat_clr) m_stat = 0;
    else if (can && found && m_stat != 32'hFFFF_FFFF) m_stat++;
`endif
    @(negedge clk);
    if (can && found) begin
      d = req_data[g*W +: W];
      m_full = 1;
      m_data = req_rev[g] ? m_g2b(d) : m_b2g(d);
      m_tag  = g;
      m_rev  = req_rev[g];
      m_ptr  = (g + 1) % N;
      req_valid[g] = 1'b0;
    end else if (m_full && out_ready) begin
      m_full = 0;
    end
    chk("out_valid", 32'(out_valid), 32'(m_full));
    if (m_full) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_tag", 32'(out_tag), 32'(m_tag));
      chk("out_rev", 32'(out_rev), 32'(m_rev));
    end
`ifdef HS_ARITH_GCS_STAT_EN
    chk("stat_grants", stat_grants, m_stat);
`endif
  endtask

  // Asserts reset at the current (falling-edge) time, checks the immediate effect, releases.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_rev", 32'(out_rev), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    m_full = 0;
    m_data = '0;
    m_tag  = 0;
    m_rev  = 0;
    m_ptr  = 0;
    m_stat = 0;
`ifdef HS_ARITH_GCS_STAT_EN
    chk("rst_stat", stat_grants, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_rev   = '0;
    req_data  = '0;
    out_ready = 1'b1;
`ifdef HS_ARITH_GCS_STAT_EN
    stat_clr  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    do_reset();

    // Pin the model converters
    chk("model_b2g_2D", 32'(m_b2g(8'h2D)), 32'h3B);
    chk("model_g2b_3B", 32'(m_g2b(8'h3B)), 32'h2D);
    chk("model_b2g_FF", 32'(m_b2g(8'hFF)), 32'h80);
    chk("model_g2b_80", 32'(m_g2b(8'h80)), 32'hFF);

    // Directed conversions
    req_valid = 4'b0001; req_rev[0] = 1'b0; req_data[7:0] = 8'h2D;
    step();
    chk("d_fwd2D_valid", 32'(out_valid), 32'd1);
    chk("d_fwd2D_data", 32'(out_data), 32'h3B);
    chk("d_fwd2D_tag", 32'(out_tag), 32'd0);
    chk("d_fwd2D_rev", 32'(out_rev), 32'd0);
    req_valid = 4'b0100; req_rev[2] = 1'b1; req_data[23:16] = 8'h3B;
    step();
    chk("d_rev3B_data", 32'(out_data), 32'h2D);
    chk("d_rev3B_tag", 32'(out_tag), 32'd2);
    req_valid = 4'b1000; req_rev[3] = 1'b0; req_data[31:24] = 8'hFF;
    step();
    chk("d_fwdFF_data", 32'(out_data), 32'h80);
    req_valid = 4'b0001; req_rev[0] = 1'b1; req_data[7:0] = 8'h80;
    step();
    chk("d_rev80_data", 32'(out_data), 32'hFF);
    step();
    chk("d_drain", 32'(out_valid), 32'd0);

    // All requesters valid: strict rotation from requester 0
    do_reset();
    req_rev = '0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 4'hF;
      req_data  = $urandom;
      step();
      chk("rr_tag", 32'(out_tag), 32'(c % N));
    end

    // Backpressure then simultaneous drain + grant
    do_reset();
    req_valid = 4'b0001; req_rev = '0; req_data[7:0] = 8'h2D; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    req_valid[1] = 1'b1; req_data[15:8] = 8'h11;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_hold_data", 32'(out_data), 32'h3B);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_swap_valid", 32'(out_valid), 32'd1);
    chk("bp_swap_data", 32'(out_data), 32'h19);
    chk("bp_swap_tag", 32'(out_tag), 32'd1);

    // Reset while FULL with requesters 1 and 3 pending
    out_ready = 1'b0;
    req_valid = 4'b1010;
    step();
    do_reset();
    out_ready = 1'b1;
    step();
    chk("rst_then_req1", 32'(out_tag), 32'd1);
    req_valid = 4'b1011;
    do_reset();
    step();
    chk("rst_then_req0", 32'(out_tag), 32'd0);

`ifdef HS_ARITH_GCS_STAT_EN
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req_valid[0] = 1'b1;
      step();
    end
    chk("stat_ten", stat_grants, 32'd10);
    req_valid[0] = 1'b1; stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("stat_clr_wins", stat_grants, 32'd0);
`endif

    // Randomized traffic
    do_reset();
    req_valid = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_rev[i]   = 1'($urandom_range(0, 1));
          req_data[i*W +: W] = W'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef HS_ARITH_GCS_STAT_EN
      stat_clr = ($urandom_range(0, 31) == 0);
`endif
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
